// File: rtl/ts_readout_ser_pkg.sv
// Shared types and frame constants for the timestamp readout serializer.
package ts_readout_ser_pkg;

  localparam int   DEFAULT_WORDWIDTH = 16;
  localparam logic START_BIT         = 1'b1;
  localparam logic STOP_BIT          = 1'b0;
  localparam int   FRAME_BITS        = DEFAULT_WORDWIDTH + 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_LOAD,
    ST_SEND
  } state_t;

  // Frame length for an arbitrary word width: start + data + parity + stop.
  function automatic int frame_bits(input int ww);
    return ww + 3;
  endfunction

endpackage

// File: rtl/ts_readout_ser_bit.sv
// Bit-period divider: DIV-cycle down-counter emitting a one-cycle bit_tick.
module ts_bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_tick
);

  localparam logic [7:0] RELOAD = 8'(DIV - 1);

  logic [7:0] div_cnt;

  // Held at RELOAD while idle so the first bit of a frame lasts exactly DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_cnt <= '0;
    else if (!run || div_cnt == 8'd0)
      div_cnt <= RELOAD;
    else
      div_cnt <= div_cnt - 8'd1;
  end

  assign bit_tick = run && (div_cnt == 8'd0);

endmodule

// File: rtl/ts_readout_ser.sv
// Reads timestamp words from a sync FIFO and sends each as a framed serial word.
module ts_readout_ser
  import ts_readout_ser_pkg::*;
#(
  parameter int WORDWIDTH = DEFAULT_WORDWIDTH,
  parameter int DIV       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 fifo_empty_i,
  input  logic [WORDWIDTH-1:0] fifo_data_i,
  output logic                 fifo_re_o,
  output logic                 ser_o,
  output logic                 frame_o,
  output logic                 busy_o,
  output logic [7:0]           word_cnt_o
);

  localparam int NBITS = frame_bits(WORDWIDTH);
  localparam int BCW   = $clog2(NBITS);
  localparam logic [BCW-1:0] PAR_BIT  = BCW'(WORDWIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(NBITS - 1);

  state_t               state, state_nxt;
  logic [WORDWIDTH-1:0] shreg;
  logic                 parity;
  logic [BCW-1:0]       bit_cnt;
  logic [7:0]           word_cnt;
  logic                 bit_tick;
  logic                 start_ok;
  logic                 frame_end;

  ts_bit_timer #(.DIV(DIV)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (state == ST_SEND),
    .bit_tick (bit_tick)
  );

  assign start_ok  = en_i && !fifo_empty_i;
  assign frame_end = (state == ST_SEND) && bit_tick && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok) state_nxt = ST_READ;
      ST_READ: state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: if (frame_end) state_nxt = start_ok ? ST_READ : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      parity   <= 1'b0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      if (state == ST_LOAD) begin
        shreg   <= fifo_data_i;
        parity  <= ^fifo_data_i;
        bit_cnt <= '0;
      end else if (state == ST_SEND && bit_tick) begin
        // The start bit does not consume a data bit; shifting past the data is harmless.
        if (bit_cnt != '0) shreg <= shreg << 1;
        bit_cnt <= frame_end ? '0 : bit_cnt + BCW'(1);
      end
      if (frame_end) word_cnt <= word_cnt + 8'd1;
    end
  end

  always_comb begin
    ser_o = 1'b0;
    if (state == ST_SEND) begin
      if (bit_cnt == '0)           ser_o = START_BIT;
      else if (bit_cnt == PAR_BIT) ser_o = parity;
      else if (bit_cnt == LAST_BIT) ser_o = STOP_BIT;
      else                         ser_o = shreg[WORDWIDTH-1];
    end
  end

  assign fifo_re_o  = (state == ST_READ);
  assign frame_o    = (state == ST_SEND);
  assign busy_o     = (state != ST_IDLE);
  assign word_cnt_o = word_cnt;

endmodule

// File: tb/tb_ts_readout_ser.sv
// Bench: two serializers (DIV=1 and DIV=4) sharing stimulus, checked against a frame-timeline model.
module tb_ts_readout_ser;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:1023];
  logic [9:0]  wr  = '0;
  logic [9:0]  rd0 = '0;
  logic [9:0]  rd1 = '0;
  logic [1:0]  fempty;
  logic [15:0] fdata0 = '0;
  logic [15:0] fdata1 = '0;
  logic [1:0]  re_v, ser_v, frame_v, busy_v;
  logic [7:0]  cnt0, cnt1;

  assign fempty[0] = (rd0 == wr);
  assign fempty[1] = (rd1 == wr);

  ts_readout_ser #(.WORDWIDTH(16), .DIV(1)) dut0 (
    .clk(clk), .rst(rst), .en_i(en), .fifo_empty_i(fempty[0]), .fifo_data_i(fdata0),
    .fifo_re_o(re_v[0]), .ser_o(ser_v[0]), .frame_o(frame_v[0]), .busy_o(busy_v[0]),
    .word_cnt_o(cnt0));

  ts_readout_ser #(.WORDWIDTH(16), .DIV(4)) dut1 (
    .clk(clk), .rst(rst), .en_i(en), .fifo_empty_i(fempty[1]), .fifo_data_i(fdata1),
    .fifo_re_o(re_v[1]), .ser_o(ser_v[1]), .frame_o(frame_v[1]), .busy_o(busy_v[1]),
    .word_cnt_o(cnt1));

  // FIFO read side: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (re_v[0]) begin fdata0 <= mem[rd0]; rd0 <= rd0 + 10'd1; end
    if (re_v[1]) begin fdata1 <= mem[rd1]; rd1 <= rd1 + 10'd1; end
  end

  // Timeline model: phase 0 idle, 1 read, 2 load, 3 sending (tt = cycle within frame).
  int          divs [2] = '{1, 4};
  int          ph   [2] = '{0, 0};
  int          tt   [2] = '{0, 0};
  logic [9:0]  mrd  [2] = '{10'd0, 10'd0};
  logic [15:0] mw   [2] = '{16'd0, 16'd0};
  logic [7:0]  ecnt [2] = '{8'd0, 8'd0};
  logic        go;

  function automatic int fbit(input logic [15:0] w, input int k);
    if (k == 0)  return 1;
    if (k <= 16) return int'(w[16-k]);
    if (k == 17) return int'(^w);
    return 0;
  endfunction

  function automatic logic [18:0] frm(input logic [15:0] w);
    return {1'b1, w, ^w, 1'b0};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin ph[i] = 0; tt[i] = 0; ecnt[i] = 8'd0; end
    end else begin
      for (int i = 0; i < 2; i++) begin
        go = en && (mrd[i] != wr);
        case (ph[i])
          0: if (go) ph[i] = 1;
          1: begin mw[i] = mem[mrd[i]]; mrd[i] = mrd[i] + 10'd1; ph[i] = 2; end
          2: begin ph[i] = 3; tt[i] = 0; end
          default: begin
            if (tt[i] == 19 * divs[i] - 1) begin
              ecnt[i] = ecnt[i] + 8'd1;
              ph[i] = go ? 1 : 0;
            end else tt[i] = tt[i] + 1;
          end
        endcase
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Frame recorder: bit value at the first cycle of each bit period, lengths and gaps.
  int          flen [2] = '{0, 0};
  int          fgap [2] = '{0, 0};
  int          last_len [2] = '{0, 0};
  int          last_gap [2] = '{0, 0};
  int          frames [2] = '{0, 0};
  int          re_cnt [2] = '{0, 0};
  logic [18:0] bits [2];
  logic [18:0] last_bits [2];
  logic [18:0] prev_bits [2];

  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        flen[i] = 0;
      end else begin
        chk($sformatf("re%0d", i),    int'(re_v[i]),    int'(ph[i] == 1));
        chk($sformatf("busy%0d", i),  int'(busy_v[i]),  int'(ph[i] != 0));
        chk($sformatf("frame%0d", i), int'(frame_v[i]), int'(ph[i] == 3));
        chk($sformatf("ser%0d", i),   int'(ser_v[i]),
            (ph[i] == 3) ? fbit(mw[i], tt[i] / divs[i]) : 0);
        chk($sformatf("cnt%0d", i),   int'(i == 0 ? cnt0 : cnt1), int'(ecnt[i]));
        if (re_v[i]) re_cnt[i]++;
        if (frame_v[i]) begin
          if (flen[i] == 0) last_gap[i] = fgap[i];
          if (flen[i] % divs[i] == 0) bits[i] = {bits[i][17:0], ser_v[i]};
          flen[i]++;
        end else begin
          if (flen[i] != 0) begin
            last_len[i]  = flen[i];
            prev_bits[i] = last_bits[i];
            last_bits[i] = bits[i];
            frames[i]++;
            flen[i] = 0;
            fgap[i] = 0;
          end
          fgap[i]++;
        end
      end
    end
  end

  task automatic push(input logic [15:0] w);
    mem[wr] = w;
    wr = wr + 10'd1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_re"},    int'(re_v),    0);
    chk({tag, "_ser"},   int'(ser_v),   0);
    chk({tag, "_frame"}, int'(frame_v), 0);
    chk({tag, "_busy"},  int'(busy_v),  0);
    chk({tag, "_cnt0"},  int'(cnt0),    0);
    chk({tag, "_cnt1"},  int'(cnt1),    0);
  endtask

  int f0, f1, r0, r1, k;

  initial begin
    #1 rst = 1'b1;
    cyc(3);
    chk_all_zero("reset");
    rst = 1'b0;
    en  = 1'b1;

    // Single word, DIV=1 and DIV=4.
    cyc(1);
    push(16'h5555);
    cyc(100);
    chk("A0_bits", int'(last_bits[0]), int'(19'b1_0101010101010101_0_0));
    chk("A0_len",  last_len[0], 19);
    chk("A0_cnt",  int'(cnt0), 1);
    chk("A0_re",   re_cnt[0], 1);
    chk("A1_bits", int'(last_bits[1]), int'(19'b1_0101010101010101_0_0));
    chk("A1_len",  last_len[1], 76);

    // Back-to-back words.
    push(16'h8001);
    push(16'h0003);
    cyc(200);
    chk("B1_first", int'(prev_bits[1]), int'(19'b1_1000000000000001_0_0));
    chk("B1_second", int'(last_bits[1]), int'(19'b1_0000000000000011_0_0));
    chk("B1_len",  last_len[1], 76);
    chk("B1_gap",  last_gap[1], 2);
    chk("B0_gap",  last_gap[0], 2);
    chk("B1_cnt",  int'(cnt1), 3);
    chk("B0_cnt",  int'(cnt0), 3);

    // Enable dropped mid-frame.
    f0 = frames[0]; f1 = frames[1]; r0 = re_cnt[0]; r1 = re_cnt[1];
    push(16'hC0DE);
    cyc(10);
    en = 1'b0;
    push(16'h7777);
    cyc(120);
    chk("C0_re_off", re_cnt[0] - r0, 1);
    chk("C1_re_off", re_cnt[1] - r1, 1);
    chk("C0_frm_off", frames[0] - f0, 1);
    chk("C1_frm_off", frames[1] - f1, 1);
    en = 1'b1;
    cyc(120);
    chk("C0_re_on", re_cnt[0] - r0, 2);
    chk("C1_re_on", re_cnt[1] - r1, 2);
    chk("C1_bits",  int'(last_bits[1]), int'(frm(16'h7777)));

    // Reset mid-frame, asserted between clock edges.
    push(16'hA5C3);
    push(16'h1234);
    cyc(36);
    #2 rst = 1'b1;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    cyc(120);
    chk("D1_bits", int'(last_bits[1]), int'(frm(16'h1234)));
    chk("D1_cnt",  int'(cnt1), 1);
    chk("D0_cnt",  int'(cnt0), 0);

    // Enabled but empty.
    r0 = re_cnt[0]; r1 = re_cnt[1];
    cyc(100);
    chk("E_re0", re_cnt[0] - r0, 0);
    chk("E_re1", re_cnt[1] - r1, 0);
    chk("E_busy", int'(busy_v), 0);

    // 256 frames: counter wraps back to its starting value.
    r0 = re_cnt[0]; r1 = re_cnt[1];
    for (int i = 0; i < 256; i++) push(16'($urandom));
    k = 0;
    while ((re_cnt[1] - r1 < 256 || busy_v != 2'b00) && k < 25000) begin cyc(1); k++; end
    chk("F_done", int'(k < 25000), 1);
    chk("F_re0", re_cnt[0] - r0, 256);
    chk("F_re1", re_cnt[1] - r1, 256);
    chk("F_cnt0", int'(cnt0), 0);
    chk("F_cnt1", int'(cnt1), 1);

    // Random pushes and enable toggling, then drain.
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      if ($urandom_range(0, 7) == 0) push(16'($urandom));
      if ($urandom_range(0, 19) == 0) en = ~en;
    end
    en = 1'b1;
    k = 0;
    while ((fempty != 2'b11 || busy_v != 2'b00) && k < 4000) begin cyc(1); k++; end
    chk("G_drain", int'(k < 4000), 1);
    chk("G_cnt_match", int'(cnt0 + 8'd1), int'(cnt1));

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
